// File: rtl/ddr2_traffic_gen_pkg.sv
// ----------------------------------------------------------------------------
// ddr2_tg_pkg
// Shared types and widths for the DDR2 traffic generator: FSM state encoding,
// user-side address width, data width, error counter width and word index
// width, plus a saturating increment helper for the error counter.
// No ports (package).
// ----------------------------------------------------------------------------
package ddr2_tg_pkg;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 64;
    localparam int ERR_W  = 16;
    localparam int IDX_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_WAIT = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_DONE    = 3'd5
    } tg_state_e;

    // Error counter increment that sticks at all-ones instead of wrapping
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        if (v == {ERR_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/ddr2_traffic_gen_if.sv
// ----------------------------------------------------------------------------
// ddr2_traffic_gen_if
// User-side request bus between the traffic generator and a DDR2 controller.
//   c_addr     : word address to controller
//   c_data_in  : write data to controller
//   c_wr_req   : write request
//   c_rd_req   : read request
//   c_rdy      : controller ready / completion indication
//   c_data_out : read data from controller
// master = traffic generator, slave = controller.
// ----------------------------------------------------------------------------
interface ddr2_traffic_gen_if;
    import ddr2_tg_pkg::*;

    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data_in;
    logic              c_wr_req;
    logic              c_rd_req;
    logic              c_rdy;
    logic [DATA_W-1:0] c_data_out;

    modport master (
        output c_addr, c_data_in, c_wr_req, c_rd_req,
        input  c_rdy, c_data_out
    );

    modport slave (
        input  c_addr, c_data_in, c_wr_req, c_rd_req,
        output c_rdy, c_data_out
    );
endinterface

// File: rtl/ddr2_traffic_gen_pattern.sv
// ----------------------------------------------------------------------------
// ddr2_tg_pattern
// Combinational word pattern: maps a word index to its address and data.
// The same instance feeds both the write data and the readback expectation so
// the two can never disagree.
//   i_idx  : word index
//   o_addr : BASE_ADDR + idx*ADDR_STRIDE, wrapping modulo 2^26
//   o_data : {idx, ~idx}, idx zero-extended to 32 bits
// ----------------------------------------------------------------------------
module ddr2_tg_pattern
    import ddr2_tg_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 26'h0,
    parameter int                ADDR_STRIDE = 4
) (
    input  logic [IDX_W-1:0]  i_idx,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    logic [31:0] w_idx32;

    assign w_idx32 = {16'd0, i_idx};
    // 26-bit arithmetic gives the address wrap for free
    assign o_addr  = BASE_ADDR + (ADDR_W'(i_idx) * ADDR_W'(ADDR_STRIDE));
    assign o_data  = {w_idx32, ~w_idx32};

endmodule

// File: rtl/ddr2_traffic_gen.sv
// ----------------------------------------------------------------------------
// ddr2_traffic_gen
// Writes NUM_WORDS pattern words to a DDR2 controller, reads them back and
// compares. Reports pass/fail, a saturating mismatch count, the address of the
// first failure and a sticky timeout flag.
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   start          : pulse, begins a pass when not busy
//   ctrl           : controller request bus (master side)
//   busy           : pass in progress
//   done           : pass finished, held until next start
//   pass           : valid with done; no mismatch and no timeout
//   err_count      : mismatching read words, saturating
//   first_err_addr : address of first mismatch or timeout
//   timeout        : sticky, a transfer exceeded TIMEOUT cycles
// ----------------------------------------------------------------------------
module ddr2_traffic_gen
    import ddr2_tg_pkg::*;
#(
    parameter int                NUM_WORDS   = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 26'h0,
    parameter int                ADDR_STRIDE = 4,
    parameter int                TIMEOUT     = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    ddr2_traffic_gen_if.master        ctrl,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [ERR_W-1:0]          err_count,
    output logic [ADDR_W-1:0]         first_err_addr,
    output logic                      timeout
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [31:0]      TO_LAST  = 32'(TIMEOUT - 1);

    tg_state_e         r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [31:0]       r_wait_cnt, w_wait_nxt;
    logic [ADDR_W-1:0] r_c_addr;
    logic [DATA_W-1:0] r_c_data_in;
    logic [DATA_W-1:0] r_exp_data;
    logic              r_wr_req, r_rd_req;
    logic              r_busy, r_done, r_pass;
    logic              r_timeout, w_timeout_nxt;
    logic [ERR_W-1:0]  r_err_count, w_err_nxt;
    logic [ADDR_W-1:0] r_fea, w_fea_nxt;
    logic [ADDR_W-1:0] w_pat_addr;
    logic [DATA_W-1:0] w_pat_data;
    logic              w_in_xfer, w_to_hit, w_last, w_mismatch, w_enter_req;

    // The pattern is looked up for the index the FSM is about to use, so the
    // address/data registers load in the same edge that enters a REQ state.
    ddr2_tg_pattern #(
        .BASE_ADDR   (BASE_ADDR),
        .ADDR_STRIDE (ADDR_STRIDE)
    ) u_pattern (
        .i_idx  (w_idx_nxt),
        .o_addr (w_pat_addr),
        .o_data (w_pat_data)
    );

    assign w_in_xfer   = (r_state == S_WR_REQ) || (r_state == S_WR_WAIT) ||
                         (r_state == S_RD_REQ) || (r_state == S_RD_WAIT);
    assign w_to_hit    = (r_wait_cnt >= TO_LAST);
    assign w_last      = (r_idx == LAST_IDX);
    assign w_mismatch  = (ctrl.c_data_out != r_exp_data);
    assign w_enter_req = (w_state_nxt != r_state) &&
                         ((w_state_nxt == S_WR_REQ) || (w_state_nxt == S_RD_REQ));
    // Counter restarts on every state change, so each REQ and WAIT phase gets
    // its own TIMEOUT budget.
    assign w_wait_nxt  = (w_in_xfer && (w_state_nxt == r_state)) ? (r_wait_cnt + 32'd1) : 32'd0;

    // Next-state and next-status logic
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_err_nxt     = r_err_count;
        w_fea_nxt     = r_fea;
        w_timeout_nxt = r_timeout;
        if (w_in_xfer && !ctrl.c_rdy && w_to_hit) begin
            w_state_nxt   = S_DONE;
            w_timeout_nxt = 1'b1;
            w_fea_nxt     = (r_err_count == 16'd0) ? r_c_addr : r_fea;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_nxt   = S_WR_REQ;
                        w_idx_nxt     = 16'd0;
                        w_err_nxt     = 16'd0;
                        w_fea_nxt     = 26'd0;
                        w_timeout_nxt = 1'b0;
                    end else begin
                        w_state_nxt   = r_state;
                    end
                end
                S_WR_REQ: begin
                    if (ctrl.c_rdy) begin
                        w_state_nxt = S_WR_WAIT;
                    end else begin
                        w_state_nxt = S_WR_REQ;
                    end
                end
                S_WR_WAIT: begin
                    if (ctrl.c_rdy && w_last) begin
                        w_state_nxt = S_RD_REQ;
                        w_idx_nxt   = 16'd0;
                    end else if (ctrl.c_rdy) begin
                        w_state_nxt = S_WR_REQ;
                        w_idx_nxt   = r_idx + 16'd1;
                    end else begin
                        w_state_nxt = S_WR_WAIT;
                    end
                end
                S_RD_REQ: begin
                    if (ctrl.c_rdy) begin
                        w_state_nxt = S_RD_WAIT;
                    end else begin
                        w_state_nxt = S_RD_REQ;
                    end
                end
                S_RD_WAIT: begin
                    if (ctrl.c_rdy) begin
                        w_err_nxt   = w_mismatch ? sat_inc(r_err_count) : r_err_count;
                        w_fea_nxt   = (w_mismatch && (r_err_count == 16'd0) && !r_timeout) ? r_c_addr : r_fea;
                        w_state_nxt = w_last ? S_DONE : S_RD_REQ;
                        w_idx_nxt   = w_last ? r_idx : (r_idx + 16'd1);
                    end else begin
                        w_state_nxt = S_RD_WAIT;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // FSM state, word index and per-state wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 16'd0;
            r_wait_cnt <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Controller-side request, address, write data and readback expectation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_req    <= 1'b0;
            r_rd_req    <= 1'b0;
            r_c_addr    <= 26'd0;
            r_c_data_in <= 64'd0;
            r_exp_data  <= 64'd0;
        end else begin
            r_wr_req <= (w_state_nxt == S_WR_REQ);
            r_rd_req <= (w_state_nxt == S_RD_REQ);
            if (w_enter_req) begin
                r_c_addr <= w_pat_addr;
            end
            if (w_enter_req && (w_state_nxt == S_WR_REQ)) begin
                r_c_data_in <= w_pat_data;
            end
            if (w_enter_req && (w_state_nxt == S_RD_REQ)) begin
                r_exp_data <= w_pat_data;
            end
        end
    end

    // Status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 16'd0;
            r_fea       <= 26'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_busy      <= (w_state_nxt == S_WR_REQ) || (w_state_nxt == S_WR_WAIT) ||
                           (w_state_nxt == S_RD_REQ) || (w_state_nxt == S_RD_WAIT);
            r_done      <= (w_state_nxt == S_DONE);
            r_pass      <= (w_state_nxt == S_DONE) && (w_err_nxt == 16'd0) && !w_timeout_nxt;
            r_err_count <= w_err_nxt;
            r_fea       <= w_fea_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign ctrl.c_addr    = r_c_addr;
    assign ctrl.c_data_in = r_c_data_in;
    assign ctrl.c_wr_req  = r_wr_req;
    assign ctrl.c_rd_req  = r_rd_req;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err_count;
    assign first_err_addr = r_fea;
    assign timeout        = r_timeout;

endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// ----------------------------------------------------------------------------
// tb_ddr2_traffic_gen
// Drives the traffic generator against a randomized memory responder. The
// expected bus transactions and final status of each pass are pushed into
// queues when the pass is started; a monitor pops and compares them as the
// DUT presents requests and raises done.
// ----------------------------------------------------------------------------
module tb_ddr2_traffic_gen;

    localparam int          N      = 16;
    localparam logic [25:0] BASE   = 26'h3FFFFE0;
    localparam int          STRIDE = 4;
    localparam int          TO     = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [25:0] first_err_addr;

    ddr2_traffic_gen_if bus();

    ddr2_traffic_gen #(
        .NUM_WORDS   (N),
        .BASE_ADDR   (BASE),
        .ADDR_STRIDE (STRIDE),
        .TIMEOUT     (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .ctrl           (bus.master),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_rd; logic [25:0] addr; logic [63:0] data; } txn_t;
    typedef struct { logic [15:0] err; logic [25:0] fea; logic to; logic ps; } st_t;

    txn_t exp_txn_q[$];
    st_t  exp_st_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int unsigned cyc = 0;

    // responder control and state
    bit          stall_mode    = 1'b0;
    logic [15:0] corrupt_mask  = 16'd0;
    logic [63:0] mem [logic [25:0]];
    bit          rs_busy       = 1'b0;
    int          rs_lat        = 0;
    bit          rs_rd         = 1'b0;
    int          rs_idx        = 0;
    logic [25:0] rs_addr       = 26'd0;
    int          rd_acc_cnt    = 0;
    int          wr_acc_cnt    = 0;
    int unsigned first_acc_cyc = 0;
    int unsigned done_cyc      = 0;
    int          done_seen     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference pattern: plain arithmetic, modulo 2^26
    function automatic logic [25:0] m_addr(input int i);
        longint unsigned a;
        a = (longint'(BASE) + longint'(i) * longint'(STRIDE)) % 64'd67108864;
        return a[25:0];
    endfunction

    function automatic logic [63:0] m_data(input int i);
        logic [31:0] u;
        u = i;
        return {u, ~u};
    endfunction

    // build the expected outcome of one pass, then pulse start
    task automatic issue_pass(input logic [15:0] mask, input bit stall);
        st_t  s;
        txn_t t;
        int   nerr;
        int   first;
        nerr  = 0;
        first = -1;
        corrupt_mask = mask;
        stall_mode   = stall;
        mem.delete();
        rs_busy    = 1'b0;
        rd_acc_cnt = 0;
        wr_acc_cnt = 0;
        if (stall) begin
            t = '{is_rd: 1'b0, addr: m_addr(0), data: m_data(0)};
            exp_txn_q.push_back(t);
            s = '{err: 16'd0, fea: m_addr(0), to: 1'b1, ps: 1'b0};
        end else begin
            for (int i = 0; i < N; i++) begin
                t = '{is_rd: 1'b0, addr: m_addr(i), data: m_data(i)};
                exp_txn_q.push_back(t);
            end
            for (int i = 0; i < N; i++) begin
                t = '{is_rd: 1'b1, addr: m_addr(i), data: m_data(i)};
                exp_txn_q.push_back(t);
                if (mask[i]) begin
                    nerr++;
                    if (first < 0) first = i;
                end
            end
            s.err = 16'(nerr);
            s.fea = (first < 0) ? 26'd0 : m_addr(first);
            s.to  = 1'b0;
            s.ps  = (nerr == 0);
        end
        exp_st_q.push_back(s);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base;
        int k;
        base = done_seen;
        k    = 0;
        while (done_seen == base && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_within_budget", 64'(done_seen != base), 64'd1);
    endtask

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory responder: decides at negedge what the next edge will see,
    // drives c_rdy/c_data_out 1 time unit after the edge.
    initial begin : responder
        logic [63:0] rd_val;
        bus.c_rdy      = 1'b0;
        bus.c_data_out = 64'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rs_busy = 1'b0;
            end else if (!rs_busy) begin
                if (bus.c_rdy && (bus.c_wr_req || bus.c_rd_req)) begin
                    rs_busy = 1'b1;
                    rs_lat  = $urandom_range(1, 5);
                    rs_addr = bus.c_addr;
                    rs_rd   = bus.c_rd_req;
                    if (!rs_rd) begin
                        mem[bus.c_addr] = bus.c_data_in;
                        if (wr_acc_cnt == 0) first_acc_cyc = cyc;
                        wr_acc_cnt++;
                    end else begin
                        rs_idx = rd_acc_cnt;
                        rd_acc_cnt++;
                    end
                end
            end else if (bus.c_rdy) begin
                rs_busy = 1'b0;
            end else if (rs_lat > 0) begin
                rs_lat--;
            end
            @(posedge clk);
            #1;
            if (rs_busy && (stall_mode || rs_lat > 0)) begin
                bus.c_rdy = 1'b0;
            end else if (rs_busy) begin
                bus.c_rdy = 1'b1;
                if (rs_rd) begin
                    rd_val = mem.exists(rs_addr) ? mem[rs_addr] : 64'd0;
                    if (corrupt_mask[rs_idx]) rd_val = rd_val ^ ({$urandom, $urandom} | 64'd1);
                    bus.c_data_out = rd_val;
                end
            end else begin
                bus.c_rdy = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: protocol checks, transaction scoreboard, final status
    initial begin : monitor
        bit          prev_hold;
        bit          prev_acc;
        bit          prev_done;
        bit          prev_rd;
        logic [25:0] prev_addr;
        logic [63:0] prev_data;
        logic        req_any;
        txn_t        t;
        st_t         s;
        prev_hold = 1'b0;
        prev_acc  = 1'b0;
        prev_done = 1'b0;
        prev_rd   = 1'b0;
        prev_addr = 26'd0;
        prev_data = 64'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_hold = 1'b0;
                prev_acc  = 1'b0;
                prev_done = 1'b0;
            end else begin
                req_any = bus.c_wr_req | bus.c_rd_req;
                if (prev_acc) chk("req_drop_after_accept", 64'(req_any), 64'd0);
                if (prev_hold) begin
                    chk("req_held", 64'(req_any), 64'd1);
                    chk("req_kind_stable", 64'(bus.c_rd_req), 64'(prev_rd));
                    chk("addr_stable", 64'(bus.c_addr), 64'(prev_addr));
                    chk("wdata_stable", bus.c_data_in, prev_data);
                end
                prev_acc  = 1'b0;
                prev_hold = 1'b0;
                if (req_any) begin
                    chk("one_req", 64'(bus.c_wr_req & bus.c_rd_req), 64'd0);
                    if (bus.c_rdy) begin
                        chk("txn_expected", 64'(exp_txn_q.size() != 0), 64'd1);
                        if (exp_txn_q.size() != 0) begin
                            t = exp_txn_q.pop_front();
                            chk("txn_kind", 64'(bus.c_rd_req), 64'(t.is_rd));
                            chk("txn_addr", 64'(bus.c_addr), 64'(t.addr));
                            if (!t.is_rd) chk("txn_wdata", bus.c_data_in, t.data);
                        end
                        prev_acc = 1'b1;
                    end else begin
                        prev_hold = 1'b1;
                        prev_rd   = bus.c_rd_req;
                        prev_addr = bus.c_addr;
                        prev_data = bus.c_data_in;
                    end
                end
                if (done && !prev_done) begin
                    done_seen++;
                    done_cyc = cyc;
                    chk("status_expected", 64'(exp_st_q.size() != 0), 64'd1);
                    if (exp_st_q.size() != 0) begin
                        s = exp_st_q.pop_front();
                        chk("err_count", 64'(err_count), 64'(s.err));
                        chk("first_err_addr", 64'(first_err_addr), 64'(s.fea));
                        chk("timeout", 64'(timeout), 64'(s.to));
                        chk("pass", 64'(pass), 64'(s.ps));
                        chk("busy_at_done", 64'(busy), 64'd0);
                    end
                    chk("leftover_txns", 64'(exp_txn_q.size()), 64'd0);
                    exp_txn_q.delete();
                end
                prev_done = done;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_wr_req"}, 64'(bus.c_wr_req), 64'd0);
        chk({tag, "_rd_req"}, 64'(bus.c_rd_req), 64'd0);
        chk({tag, "_addr"}, 64'(bus.c_addr), 64'd0);
        chk({tag, "_wdata"}, bus.c_data_in, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_err_count"}, 64'(err_count), 64'd0);
        chk({tag, "_first_err_addr"}, 64'(first_err_addr), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    endtask

    initial begin : stimulus
        bool_found_blk: begin end
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // clean pass, with a start pulse while busy that must be ignored
        issue_pass(16'h0000, 1'b0);
        repeat (10) @(negedge clk);
        chk("busy_mid_pass", 64'(busy), 64'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3000);
        repeat (5) @(negedge clk);
        chk("done_held", 64'(done), 64'd1);
        chk("pass_held", 64'(pass), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);

        // single corrupted read at word 5
        issue_pass(16'h0020, 1'b0);
        wait_done(3000);

        // random corruption patterns
        for (int r = 0; r < 3; r++) begin
            issue_pass(16'($urandom_range(0, 65535)), 1'b0);
            wait_done(3000);
        end

        // every read corrupted
        issue_pass(16'hFFFF, 1'b0);
        wait_done(3000);

        // controller stalls after the first write is accepted
        issue_pass(16'h0000, 1'b1);
        wait_done(3000);
        chk("timeout_latency", 64'(((done_cyc - first_acc_cyc) >= TO) &&
                                    ((done_cyc - first_acc_cyc) <= TO + 3)), 64'd1);

        // clean pass after a timeout clears the sticky flags
        issue_pass(16'h0000, 1'b0);
        wait_done(3000);

        // reset while waiting on the fourth read
        issue_pass(16'h0000, 1'b0);
        begin
            int k;
            k = 0;
            while (rd_acc_cnt < 4 && k < 3000) begin
                @(posedge clk);
                #2;
                k++;
            end
            chk("reached_read3", 64'(rd_acc_cnt >= 4), 64'd1);
        end
        rst = 1'b0;
        #1;
        check_reset_values("midreset");
        exp_txn_q.delete();
        exp_st_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("no_req_after_reset", 64'(bus.c_wr_req | bus.c_rd_req), 64'd0);
        end
        issue_pass(16'h0000, 1'b0);
        wait_done(3000);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr2_traffic_gen.md
DDR2_TRAFFIC_GEN -- requirements
Module: ddr2_traffic_gen

Interface
REQ-001 Parameter NUM_WORDS, default 16, number of 64-bit words written then read back (range 1..65535).
REQ-002 Parameter BASE_ADDR, default 26'h0, first user-side word address.
REQ-003 Parameter ADDR_STRIDE, default 4, address increment per word (one BL4 x16 burst).
REQ-004 Parameter TIMEOUT, default 4096, maximum cycles waiting on c_rdy per transfer.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  pulse; begins a write/readback pass when idle.
REQ-008 c_addr  output  26  word address to controller.
REQ-009 c_data_in  output  64  write data to controller.
REQ-010 c_wr_req  output  1  write request.
REQ-011 c_rd_req  output  1  read request.
REQ-012 c_rdy  input  1  controller ready / completion indication.
REQ-013 c_data_out  input  64  read data from controller.
REQ-014 busy  output  1  pass in progress.
REQ-015 done  output  1  pass finished; held until next start.
REQ-016 pass  output  1  valid with done; 1 = no mismatch and no timeout.
REQ-017 err_count  output  16  mismatching read words, saturating at 16'hFFFF.
REQ-018 first_err_addr  output  26  address of first mismatch or timeout.
REQ-019 timeout  output  1  sticky; a transfer exceeded TIMEOUT.

Function
REQ-020 Handshake: request accepted in the cycle c_*_req=1 and c_rdy=1; c_addr/c_data_in held stable from assertion until acceptance; request deasserted the cycle after acceptance.
REQ-021 Completion: after acceptance, the first cycle with c_rdy=1 (no earlier than 1 cycle after acceptance) completes the transfer; for reads, c_data_out is sampled in that cycle.
REQ-022 Never assert c_wr_req and c_rd_req together; at most one transfer outstanding.
REQ-023 Word i address = BASE_ADDR + i*ADDR_STRIDE, modulo 2^26 (wrap, no error).
REQ-024 Word i data = {i[31:0], ~i[31:0]}, i zero-extended to 32 bits.
REQ-025 FSM states: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE.
REQ-026 IDLE -> WR_REQ on start; index cleared, err_count/timeout/first_err_addr cleared, done=0.
REQ-027 WR_REQ -> WR_WAIT on acceptance; WR_WAIT -> WR_REQ (index+1) on completion, or -> RD_REQ (index=0) after word NUM_WORDS-1.
REQ-028 RD_REQ -> RD_WAIT on acceptance; RD_WAIT compares on completion, -> RD_REQ (index+1) or -> DONE after word NUM_WORDS-1.
REQ-029 Mismatch: err_count increments; first_err_addr captured only if err_count was 0 and timeout=0.
REQ-030 Wait counter resets on each state entry; reaching TIMEOUT in any REQ/WAIT state sets timeout, captures first_err_addr if none, -> DONE.
REQ-031 DONE: done=1, busy=0, pass=(err_count==0 && !timeout); start in DONE behaves as in IDLE.
REQ-032 start while busy is ignored.
REQ-033 busy=1 in WR_REQ, WR_WAIT, RD_REQ, RD_WAIT only.

Reset
REQ-034 On rst=0: state IDLE; c_wr_req=0, c_rd_req=0, c_addr=0, c_data_in=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, timeout=0.
REQ-035 Reset mid-transfer aborts immediately; no request asserted until a new start after rst=1.

Structure
REQ-036 Package ddr2_tg_pkg holds state encoding, user address width (26), data width (64), err_count width (16).
REQ-037 Sub-module ddr2_tg_pattern: combinational index -> {address, data} per REQ-023/024, shared by write and check paths.

Verification
REQ-038 Ideal responder (c_rdy low 3 cycles after accept), NUM_WORDS=16 -> 16 writes at 0,4,..,60 then 16 reads; done=1, pass=1, err_count=0.
REQ-039 Responder corrupts read data of word 5 -> err_count=1, first_err_addr=26'h14, pass=0.
REQ-040 c_rdy held 0 after first write accept, TIMEOUT=100 -> timeout=1 at cycle ~100, first_err_addr=BASE_ADDR, done=1, pass=0.
REQ-041 BASE_ADDR=26'h3FFFFF8, NUM_WORDS=4 -> addresses 3FFFFF8, 3FFFFFC, 0000000, 0000004; pass=1.
REQ-042 rst=0 asserted in RD_WAIT of word 3 -> all outputs at reset values same cycle; new start runs full clean pass.
REQ-043 Full system: traffic gen drives DDR2 controller plus DDR2 memory model -> pass=1 for NUM_WORDS=64.
